// File: rtl/ac_pkg.sv
// Shared types for the access-control output path: framer FSM states and FIFO entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ac_pkg;

   // Default pixel width; the framer's FIFO entry is sized from this value.
   localparam int AXISOUT_DATA_WIDTH = 24;
   localparam int AXISOUT_STRB_WIDTH = AXISOUT_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } framer_state_e;

   // One output beat as it sits in the FIFO: tags regenerated from the framer counters.
   typedef struct packed {
      logic                          tuser;
      logic                          tlast;
      logic [AXISOUT_DATA_WIDTH-1:0] tdata;
   } framer_entry_t;

   localparam int FRAMER_ENTRY_WIDTH = $bits(framer_entry_t);

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head entry is always visible on pop_dat.
// Latency: a push in cycle N is visible at the head in cycle N+1 (no write-to-read bypass).
// Backpressure: pushes while full and pops while empty are ignored; full/empty are registered-state decodes.
//
// Ports: clk, rst_n (sync, active-low), clr (sync flush), push/push_dat, pop/pop_dat,
//        full, empty, one_left (exactly one entry stored).
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty,
   output logic             one_left
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign one_left = (count == (AW+1)'(1));
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_dat  = mem[rd_ptr[AW-1:0]];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/axis_out_framer.sv
// Output AXI4-Stream framer: regenerates tuser/tlast from its own pixel counters and reports frame completion.
// Latency: an accepted input beat appears on m_axis one cycle later (registered FIFO write).
// Backpressure: s_axis_tready = RUN && !fifo_full, from registered state only; m_axis holds while !tready.
//
// Ports: clk, rst_n (sync, active-low), start (arm one frame), clr (sync abort),
//        s_axis_* (upstream pixels), m_axis_* (framed output), busy (RUN/DRAIN), frame_done (1-cycle pulse).
// Optional: define AXIS_OUT_FRAMER_ERRCHK_EN to add err_tlast, a sticky flag for upstream tlast
//           disagreeing with the internal column counter.
module axis_out_framer #(
   parameter int AXISOUT_DATA_WIDTH = 24,
   parameter int DST_IMG_WIDTH      = 3840,
   parameter int DST_IMG_HEIGHT     = 2160,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            clr,
   input  logic                            s_axis_tvalid,
   input  logic [AXISOUT_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                            s_axis_tlast,
   output logic                            s_axis_tready,
   output logic                            m_axis_tvalid,
   output logic [AXISOUT_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [AXISOUT_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [AXISOUT_DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tuser,
   input  logic                            m_axis_tready,
   output logic                            busy,
`ifdef AXIS_OUT_FRAMER_ERRCHK_EN
   output logic                            err_tlast,
`endif
   output logic                            frame_done
);

   // FIFO entries use the package layout, so AXISOUT_DATA_WIDTH must equal ac_pkg's value.
   import ac_pkg::*;

   localparam int CW = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
   localparam int RW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
   localparam int SW = AXISOUT_DATA_WIDTH / 8;
   localparam logic [CW-1:0] COL_LAST = CW'(DST_IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(DST_IMG_HEIGHT - 1);

   framer_state_e state_q;
   framer_state_e state_d;
   logic [CW-1:0] in_col;
   logic [RW-1:0] in_row;
   logic          last_col;
   logic          last_row;
   logic          accept;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_one;
   framer_entry_t push_entry;
   framer_entry_t head_entry;

   assign last_col      = (in_col == COL_LAST);
   assign last_row      = (in_row == ROW_LAST);
   assign s_axis_tready = (state_q == RUN) && !fifo_full;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign pop           = m_axis_tvalid && m_axis_tready;

   assign push_entry.tuser = (in_row == '0) && (in_col == '0);
   assign push_entry.tlast = last_col;
   assign push_entry.tdata = s_axis_tdata;

   sync_fifo_fwft #(
      .WIDTH (FRAMER_ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .push     (accept),
      .push_dat (push_entry),
      .pop      (pop),
      .pop_dat  (head_entry),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .one_left (fifo_one)
   );

   // Outputs are forced to zero while no beat is presented so reset/idle values are clean.
   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = m_axis_tvalid ? head_entry.tdata : '0;
   assign m_axis_tlast  = m_axis_tvalid && head_entry.tlast;
   assign m_axis_tuser  = m_axis_tvalid && head_entry.tuser;
   assign m_axis_tkeep  = m_axis_tvalid ? {SW{1'b1}} : '0;
   assign m_axis_tstrb  = m_axis_tvalid ? {SW{1'b1}} : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // DRAIN leaves as the FIFO goes empty (including the cycle that pops the last entry),
   // so frame_done lands in the cycle right after the final output handshake.
   always_comb begin
      state_d    = state_q;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE:  if (start) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (accept && last_col && last_row) state_d = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (fifo_empty || (fifo_one && pop)) state_d = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clr) state_d = IDLE;
   end

   // Raster counters; they return to 0 after the last pixel so the next frame starts clean.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         in_col <= '0;
         in_row <= '0;
      end else if (accept) begin
         if (last_col) begin
            in_col <= '0;
            in_row <= last_row ? '0 : in_row + 1'b1;
         end else begin
            in_col <= in_col + 1'b1;
         end
      end
   end

`ifdef AXIS_OUT_FRAMER_ERRCHK_EN
   logic err_q;

   // Only a start that actually arms the framer (IDLE) clears the flag.
   always_ff @(posedge clk) begin
      if (!rst_n || clr || (start && (state_q == IDLE))) err_q <= 1'b0;
      else if (accept && (s_axis_tlast != last_col))     err_q <= 1'b1;
   end

   assign err_tlast = err_q;
`else
   // Upstream tlast is not needed when framing comes purely from the counters.
   logic unused_s_axis_tlast;
   assign unused_s_axis_tlast = s_axis_tlast;
`endif

endmodule
